// File: rtl/stream_pkg.sv
// Shared stream constants, packer state encoding and tkeep helpers.
// Used by the Compressor and by stream_byte_packer.
package stream_pkg;

  localparam int DATA_WIDTH = 256;
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  // Wide enough for a byte total of up to 2*KEEP_WIDTH-1.
  localparam int CNT_W      = $clog2(KEEP_WIDTH) + 1;

  typedef enum logic {
    PACK  = 1'b0,
    FLUSH = 1'b1
  } state_e;

  typedef struct packed {
    logic [CNT_W-1:0] n;
    logic             contig;
  } keep_info_t;

  // n counts the run of ones from lane 0; contig drops if a one follows a zero.
  function automatic keep_info_t keep_count(input logic [KEEP_WIDTH-1:0] keep);
    keep_info_t r;
    logic       seen_zero;
    r.n       = '0;
    r.contig  = 1'b1;
    seen_zero = 1'b0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      if (!keep[i]) seen_zero = 1'b1;
      else if (seen_zero) r.contig = 1'b0;
      else r.n = r.n + 1'b1;
    end
    return r;
  endfunction

  // Low cnt lanes set; cnt == KEEP_WIDTH gives all ones.
  function automatic logic [KEEP_WIDTH-1:0] lane_mask(input logic [CNT_W-1:0] cnt);
    logic [KEEP_WIDTH-1:0] m;
    for (int i = 0; i < KEEP_WIDTH; i++) m[i] = (CNT_W'(i) < cnt);
    return m;
  endfunction

endpackage

// File: rtl/byte_shift_merge.sv
// Places the n valid bytes of a new beat directly above the res_cnt residue bytes.
// Purely combinational; comb is double width so overflow bytes are kept.
module byte_shift_merge
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH = stream_pkg::DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0]   res,
  input  logic [CNT_W-1:0]        res_cnt,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [CNT_W-1:0]        n,
  output logic [2*DATA_WIDTH-1:0] comb,
  output logic [CNT_W-1:0]        total
);

  localparam int KW = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0]   data_masked;
  logic [2*DATA_WIDTH-1:0] data_shifted;

  // Lanes at or above n are dropped so they cannot pollute the residue.
  always_comb begin
    data_masked = '0;
    for (int i = 0; i < KW; i++) begin
      if (CNT_W'(i) < n) data_masked[8*i +: 8] = data_in[8*i +: 8];
    end
  end

  assign data_shifted = {{DATA_WIDTH{1'b0}}, data_masked} << {res_cnt, 3'b000};
  assign comb         = {{DATA_WIDTH{1'b0}}, res} | data_shifted;
  assign total        = res_cnt + n;

endmodule

// File: rtl/stream_byte_packer.sv
// Repacks variable-length AXI-stream beats into dense beats; only the tlast beat
// of a packet may be partial. One residue register plus one output register.
module stream_byte_packer
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH = stream_pkg::DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [DATA_WIDTH/8-1:0] tkeep_in,
  input  logic                    tvalid_in,
  input  logic                    tlast_in,
  output logic                    tready_out,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic [DATA_WIDTH/8-1:0] tkeep_out,
  output logic                    tvalid_out,
  output logic                    tlast_out,
  input  logic                    tready_in,
  output logic                    keep_err
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam logic [CNT_W-1:0] KW_CNT = CNT_W'(KEEP_WIDTH);

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   res_q, res_d;
  logic [CNT_W-1:0]        res_cnt_q, res_cnt_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [KEEP_WIDTH-1:0]   keep_q, keep_d;
  logic                    vld_q, vld_d;
  logic                    last_q, last_d;
  logic                    err_q, err_d;

  keep_info_t              info;
  logic [2*DATA_WIDTH-1:0] comb;
  logic [CNT_W-1:0]        total;
  logic                    out_free;
  logic                    accept;

  assign info = keep_count(tkeep_in);

  byte_shift_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
    .res     (res_q),
    .res_cnt (res_cnt_q),
    .data_in (data_in),
    .n       (info.n),
    .comb    (comb),
    .total   (total)
  );

  assign out_free   = !vld_q || tready_in;
  assign tready_out = (state_q == PACK) && out_free;
  assign accept     = tvalid_in && tready_out;

  always_comb begin
    state_d   = state_q;
    res_d     = res_q;
    res_cnt_d = res_cnt_q;
    data_d    = data_q;
    keep_d    = keep_q;
    vld_d     = out_free ? 1'b0 : vld_q;
    last_d    = last_q;
    err_d     = err_q;

    if (state_q == FLUSH) begin
      if (out_free) begin
        data_d    = res_q;
        keep_d    = lane_mask(res_cnt_q);
        vld_d     = 1'b1;
        last_d    = 1'b1;
        res_d     = '0;
        res_cnt_d = '0;
        state_d   = PACK;
      end
    end else if (accept) begin
      if (!info.contig) err_d = 1'b1;
      if (tlast_in && total <= KW_CNT) begin
        data_d    = comb[DATA_WIDTH-1:0];
        keep_d    = lane_mask(total);
        vld_d     = 1'b1;
        last_d    = 1'b1;
        res_d     = '0;
        res_cnt_d = '0;
      end else if (total >= KW_CNT) begin
        // Full beat out; overflow bytes become the new residue.
        data_d    = comb[DATA_WIDTH-1:0];
        keep_d    = '1;
        vld_d     = 1'b1;
        last_d    = 1'b0;
        res_d     = comb[2*DATA_WIDTH-1:DATA_WIDTH];
        res_cnt_d = total - KW_CNT;
        if (tlast_in) state_d = FLUSH;
      end else begin
        res_d     = comb[DATA_WIDTH-1:0];
        res_cnt_d = total;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= PACK;
      res_q     <= '0;
      res_cnt_q <= '0;
      data_q    <= '0;
      keep_q    <= '0;
      vld_q     <= 1'b0;
      last_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      res_q     <= res_d;
      res_cnt_q <= res_cnt_d;
      data_q    <= data_d;
      keep_q    <= keep_d;
      vld_q     <= vld_d;
      last_q    <= last_d;
      err_q     <= err_d;
    end
  end

  assign data_out   = data_q;
  assign tkeep_out  = keep_q;
  assign tvalid_out = vld_q;
  assign tlast_out  = last_q;
  assign keep_err   = err_q;

endmodule

// File: tb/tb_stream_byte_packer.sv
// Directed bench for stream_byte_packer: one task per scenario, inline checks.
module tb_stream_byte_packer;

  logic         clk;
  logic         reset;
  logic [255:0] data_in;
  logic [31:0]  tkeep_in;
  logic         tvalid_in;
  logic         tlast_in;
  logic         tready_out;
  logic [255:0] data_out;
  logic [31:0]  tkeep_out;
  logic         tvalid_out;
  logic         tlast_out;
  logic         tready_in;
  logic         keep_err;

  int n_cmp = 0;
  int n_err = 0;

  stream_byte_packer dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .tkeep_in   (tkeep_in),
    .tvalid_in  (tvalid_in),
    .tlast_in   (tlast_in),
    .tready_out (tready_out),
    .data_out   (data_out),
    .tkeep_out  (tkeep_out),
    .tvalid_out (tvalid_out),
    .tlast_out  (tlast_out),
    .tready_in  (tready_in),
    .keep_err   (keep_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte i of the pattern is base+i.
  function automatic logic [255:0] mk(input logic [7:0] base);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = base + 8'(i);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one beat and returns 1ns after the edge that accepted it.
  task automatic drive(input logic [255:0] d, input logic [31:0] k, input logic l);
    int t;
    data_in   = d;
    tkeep_in  = k;
    tlast_in  = l;
    tvalid_in = 1'b1;
    t = 0;
    while (!tready_out && t < 20) begin
      step();
      t++;
    end
    n_cmp++;
    if (tready_out !== 1'b1) begin
      n_err++;
      $display("FAIL drive_timeout tready_out=%0b required 1", tready_out);
    end
    step();
    tvalid_in = 1'b0;
  endtask

  task automatic idle_drain();
    tvalid_in = 1'b0;
    tready_in = 1'b1;
    step();
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_cmp++;
    if ({tvalid_out, tlast_out, keep_err} !== 3'b000 || tkeep_out !== 32'h0 || data_out !== 256'h0) begin
      n_err++;
      $display("FAIL reset_outputs vld=%0b last=%0b err=%0b keep=%h required all zero",
               tvalid_out, tlast_out, keep_err, tkeep_out);
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if (tready_out !== 1'b1) begin
      n_err++;
      $display("FAIL reset_tready tready_out=%0b required 1", tready_out);
    end
  endtask

  task automatic test_half_beats();
    logic [255:0] exp;
    for (int i = 0; i < 32; i++) exp[8*i +: 8] = (i < 16) ? 8'(i) : 8'h40 + 8'(i - 16);
    tready_in = 1'b1;
    drive(mk(8'h00), 32'h0000FFFF, 1'b0);
    n_cmp++;
    if (tvalid_out !== 1'b0) begin
      n_err++;
      $display("FAIL half_absorb tvalid_out=%0b required 0", tvalid_out);
    end
    drive(mk(8'h40), 32'h0000FFFF, 1'b1);
    n_cmp++;
    if (tvalid_out !== 1'b1 || tlast_out !== 1'b1 || tkeep_out !== 32'hFFFFFFFF || data_out !== exp) begin
      n_err++;
      $display("FAIL half_merge vld=%0b last=%0b keep=%h data=%h required 1 1 ffffffff %h",
               tvalid_out, tlast_out, tkeep_out, data_out, exp);
    end
    idle_drain();
  endtask

  task automatic test_flush();
    logic [255:0] exp1, exp2;
    for (int i = 0; i < 32; i++) begin
      exp1[8*i +: 8] = (i < 20) ? 8'(i) : 8'h80 + 8'(i - 20);
      exp2[8*i +: 8] = (i < 8) ? 8'h8C + 8'(i) : 8'h00;
    end
    tready_in = 1'b1;
    drive(mk(8'h00), 32'h000FFFFF, 1'b0);
    drive(mk(8'h80), 32'h000FFFFF, 1'b1);
    n_cmp++;
    if (tvalid_out !== 1'b1 || tlast_out !== 1'b0 || tkeep_out !== 32'hFFFFFFFF || data_out !== exp1) begin
      n_err++;
      $display("FAIL flush_first vld=%0b last=%0b keep=%h data=%h required 1 0 ffffffff %h",
               tvalid_out, tlast_out, tkeep_out, data_out, exp1);
    end
    n_cmp++;
    if (tready_out !== 1'b0) begin
      n_err++;
      $display("FAIL flush_ready_low tready_out=%0b required 0", tready_out);
    end
    step();
    n_cmp++;
    if (tvalid_out !== 1'b1 || tlast_out !== 1'b1 || tkeep_out !== 32'h000000FF || data_out !== exp2) begin
      n_err++;
      $display("FAIL flush_tail vld=%0b last=%0b keep=%h data=%h required 1 1 000000ff %h",
               tvalid_out, tlast_out, tkeep_out, data_out, exp2);
    end
    n_cmp++;
    if (tready_out !== 1'b1) begin
      n_err++;
      $display("FAIL flush_ready_back tready_out=%0b required 1", tready_out);
    end
    idle_drain();
  endtask

  task automatic test_back_to_back();
    tready_in = 1'b1;
    drive(mk(8'h10), 32'hFFFFFFFF, 1'b0);
    n_cmp++;
    if (tvalid_out !== 1'b1 || tkeep_out !== 32'hFFFFFFFF || data_out !== mk(8'h10)) begin
      n_err++;
      $display("FAIL b2b_beat1 vld=%0b keep=%h data=%h required 1 ffffffff %h",
               tvalid_out, tkeep_out, data_out, mk(8'h10));
    end
    tready_in = 1'b0;
    data_in   = mk(8'h30);
    tkeep_in  = 32'hFFFFFFFF;
    tlast_in  = 1'b0;
    tvalid_in = 1'b1;
    step();
    n_cmp++;
    if (tvalid_out !== 1'b1 || data_out !== mk(8'h10) || tready_out !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_stall vld=%0b rdy=%0b data=%h required 1 0 %h",
               tvalid_out, tready_out, data_out, mk(8'h10));
    end
    tready_in = 1'b1;
    drive(mk(8'h30), 32'hFFFFFFFF, 1'b0);
    n_cmp++;
    if (tvalid_out !== 1'b1 || tlast_out !== 1'b0 || tkeep_out !== 32'hFFFFFFFF || data_out !== mk(8'h30)) begin
      n_err++;
      $display("FAIL b2b_beat2 vld=%0b last=%0b keep=%h data=%h required 1 0 ffffffff %h",
               tvalid_out, tlast_out, tkeep_out, data_out, mk(8'h30));
    end
    drive(mk(8'h50), 32'hFFFFFFFF, 1'b1);
    n_cmp++;
    if (tvalid_out !== 1'b1 || tlast_out !== 1'b1 || tkeep_out !== 32'hFFFFFFFF || data_out !== mk(8'h50)) begin
      n_err++;
      $display("FAIL b2b_beat3 vld=%0b last=%0b keep=%h data=%h required 1 1 ffffffff %h",
               tvalid_out, tlast_out, tkeep_out, data_out, mk(8'h50));
    end
    idle_drain();
  endtask

  task automatic test_null_beat();
    logic [255:0] exp;
    for (int i = 0; i < 32; i++) exp[8*i +: 8] = (i < 4) ? 8'hA0 + 8'(i) : 8'h00;
    tready_in = 1'b1;
    drive(mk(8'h60), 32'h00000000, 1'b1);
    n_cmp++;
    if (tvalid_out !== 1'b1 || tlast_out !== 1'b1 || tkeep_out !== 32'h0) begin
      n_err++;
      $display("FAIL null_beat vld=%0b last=%0b keep=%h required 1 1 00000000",
               tvalid_out, tlast_out, tkeep_out);
    end
    drive(mk(8'hA0), 32'h0000000F, 1'b1);
    n_cmp++;
    if (tvalid_out !== 1'b1 || tlast_out !== 1'b1 || tkeep_out !== 32'h0000000F || data_out !== exp) begin
      n_err++;
      $display("FAIL null_next vld=%0b last=%0b keep=%h data=%h required 1 1 0000000f %h",
               tvalid_out, tlast_out, tkeep_out, data_out, exp);
    end
    idle_drain();
  endtask

  task automatic test_keep_err();
    logic [255:0] exp;
    for (int i = 0; i < 32; i++) exp[8*i +: 8] = (i < 8) ? 8'(i) : 8'h00;
    tready_in = 1'b1;
    n_cmp++;
    if (keep_err !== 1'b0) begin
      n_err++;
      $display("FAIL keep_err_clear keep_err=%0b required 0", keep_err);
    end
    drive(mk(8'h00), 32'h0000F0FF, 1'b1);
    n_cmp++;
    if (tkeep_out !== 32'h000000FF || data_out !== exp || keep_err !== 1'b1) begin
      n_err++;
      $display("FAIL keep_err_beat keep=%h err=%0b data=%h required 000000ff 1 %h",
               tkeep_out, keep_err, data_out, exp);
    end
    idle_drain();
    step();
    n_cmp++;
    if (keep_err !== 1'b1) begin
      n_err++;
      $display("FAIL keep_err_sticky keep_err=%0b required 1", keep_err);
    end
  endtask

  task automatic test_mid_reset();
    logic [255:0] exp;
    for (int i = 0; i < 32; i++) exp[8*i +: 8] = (i < 4) ? 8'hC0 + 8'(i) : 8'h00;
    tready_in = 1'b1;
    drive(mk(8'h20), 32'h00000FFF, 1'b0);
    drive(mk(8'h70), 32'hFFFFFFFF, 1'b0);
    tready_in = 1'b0;
    step();
    n_cmp++;
    if (tvalid_out !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_stalled tvalid_out=%0b required 1", tvalid_out);
    end
    reset = 1'b1;
    step();
    n_cmp++;
    if (tvalid_out !== 1'b0 || tkeep_out !== 32'h0 || keep_err !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_clear vld=%0b keep=%h err=%0b required 0 00000000 0",
               tvalid_out, tkeep_out, keep_err);
    end
    reset = 1'b0;
    tready_in = 1'b1;
    step();
    drive(mk(8'hC0), 32'h0000000F, 1'b1);
    n_cmp++;
    if (tvalid_out !== 1'b1 || tlast_out !== 1'b1 || tkeep_out !== 32'h0000000F || data_out !== exp) begin
      n_err++;
      $display("FAIL midrst_fresh vld=%0b last=%0b keep=%h data=%h required 1 1 0000000f %h",
               tvalid_out, tlast_out, tkeep_out, data_out, exp);
    end
    idle_drain();
  endtask

  initial begin
    reset     = 1'b1;
    data_in   = '0;
    tkeep_in  = '0;
    tvalid_in = 1'b0;
    tlast_in  = 1'b0;
    tready_in = 1'b1;
    test_reset();
    test_half_beats();
    test_flush();
    test_back_to_back();
    test_null_beat();
    test_keep_err();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
